uart_alu_interface: RTL and testbench

Byte-serial sequencer for the combinational ALU: collects operand A, operand B and opcode from the UART receiver, drives the ALU, captures result and carry, then returns a result byte and a status byte through the UART transmitter. Sits between the UART RX/TX pair and `ALU` in the board top level. The ALU stays external and is instantiated alongside this block.

---
 rtl/alu_pkg.sv | 18 +
 rtl/uart_alu_interface.sv | 101 ++++++++++
 tb/tb_uart_alu_interface.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcode constants, status-byte layout and sequencer states.
package alu_pkg;
   localparam int SIZEDATA = 8;
   localparam int SIZEOP   = 6;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam int ST_CARRY   = 0;
   localparam int ST_ILLEGAL = 1;
   typedef enum logic [2:0] {
      GET_A, GET_B, GET_OP, EXEC, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT
   } state_t;
endpackage

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: gathers A, B, opcode bytes from UART RX, samples the external ALU,
// and returns a result byte followed by a status byte over UART TX.
module uart_alu_interface
   import alu_pkg::*;
#(
   parameter int SIZEDATA = alu_pkg::SIZEDATA,
   parameter int SIZEOP   = alu_pkg::SIZEOP
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [SIZEDATA-1:0] RX_DATA,
   input  logic                RX_DONE,
   input  logic                TX_DONE,
   input  logic [SIZEDATA-1:0] ALU_RESULT,
   input  logic                ALU_CARRY,
   output logic [SIZEDATA-1:0] DATOA,
   output logic [SIZEDATA-1:0] DATOB,
   output logic [SIZEOP-1:0]   OPCODE,
   output logic [SIZEDATA-1:0] TX_DATA,
   output logic                TX_START,
   output logic                BUSY
);
   state_t              state_q, state_d;
   logic [SIZEDATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d, status;
   logic [SIZEOP-1:0]   op_q, op_d;
   logic                ill_q, ill_d, cy_q, cy_d;

   function automatic logic is_legal(input logic [SIZEOP-1:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
   endfunction

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= GET_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         ill_q   <= 1'b0;
         cy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
         cy_q    <= cy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      ill_d   = ill_q;
      cy_d    = cy_q;
      case (state_q)
         GET_A: if (RX_DONE) begin
            a_d     = RX_DATA;
            state_d = GET_B;
         end
         GET_B: if (RX_DONE) begin
            b_d     = RX_DATA;
            state_d = GET_OP;
         end
         GET_OP: if (RX_DONE) begin
            op_d    = RX_DATA[SIZEOP-1:0];
            ill_d   = (RX_DATA[SIZEDATA-1:SIZEOP] != '0) || !is_legal(RX_DATA[SIZEOP-1:0]);
            state_d = EXEC;
         end
         EXEC: begin
            res_d   = ill_q ? '0 : ALU_RESULT;
            cy_d    = ill_q ? 1'b0 : ALU_CARRY;
            state_d = SEND_RES;
         end
         SEND_RES:  state_d = WAIT_RES;
         WAIT_RES:  state_d = TX_DONE ? SEND_STAT : WAIT_RES;
         SEND_STAT: state_d = WAIT_STAT;
         WAIT_STAT: state_d = TX_DONE ? GET_A : WAIT_STAT;
         default:   state_d = GET_A;
      endcase
   end

   always_comb begin
      status             = '0;
      status[ST_CARRY]   = cy_q;
      status[ST_ILLEGAL] = ill_q;
   end

   // TX_DATA is decoded from state so it holds steady for the whole send/wait pair.
   assign TX_DATA  = (state_q inside {SEND_STAT, WAIT_STAT}) ? status :
                     (state_q inside {SEND_RES, WAIT_RES})   ? res_q  : '0;
   assign TX_START = (state_q == SEND_RES) || (state_q == SEND_STAT);
   assign BUSY     = (state_q != GET_A);
   assign DATOA    = a_q;
   assign DATOB    = b_q;
   assign OPCODE   = op_q;
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: randomized and directed byte transactions checked against a behavioural model.
module tb_uart_alu_interface;
   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic [7:0] RX_DATA = 8'h00;
   logic       RX_DONE = 1'b0;
   logic       TX_DONE = 1'b0;
   logic [7:0] ALU_RESULT;
   logic       ALU_CARRY;
   logic [7:0] DATOA, DATOB, TX_DATA;
   logic [5:0] OPCODE;
   logic       TX_START, BUSY;

   int n_tests = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic       exp_busy = 1'b0;

   always #5 CLK = ~CLK;

   uart_alu_interface dut (
      .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_DONE(RX_DONE),
      .TX_DONE(TX_DONE), .ALU_RESULT(ALU_RESULT), .ALU_CARRY(ALU_CARRY),
      .DATOA(DATOA), .DATOB(DATOB), .OPCODE(OPCODE), .TX_DATA(TX_DATA),
      .TX_START(TX_START), .BUSY(BUSY)
   );

   // Bench-side ALU; unknown opcodes yield junk so the DUT must zero them itself.
   function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      logic [7:0] t;
      case (op)
         6'h20:   return {1'b0, a} + {1'b0, b};
         6'h22:   return {1'b0, a} - {1'b0, b};
         6'h24:   return {1'b0, a & b};
         6'h25:   return {1'b0, a | b};
         6'h26:   return {1'b0, a ^ b};
         6'h27:   return {1'b0, ~(a | b)};
         6'h03:   begin t = $signed(a) >>> b; return {1'b0, t}; end
         6'h02:   return {1'b0, a >> b};
         default: return {1'b1, a ^ b ^ 8'hA5};
      endcase
   endfunction

   always_comb {ALU_CARRY, ALU_RESULT} = alu_fn(DATOA, DATOB, OPCODE);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      logic [8:0] r;
      bit legal;
      legal = op inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
      r = alu_fn(a, b, op[5:0]);
      exp_q.push_back(legal ? r[7:0] : 8'h00);
      exp_q.push_back(legal ? {7'b0, r[8]} : 8'h02);
   endtask

   // Compare process: every cycle, away from the clock edge.
   initial begin
      logic prev = 1'b0, holding = 1'b0;
      logic [7:0] held = 8'h00, e;
      forever begin
         @(negedge CLK);
         if (!RESET_N) begin
            prev = 1'b0;
            holding = 1'b0;
            continue;
         end
         chk("busy", {31'b0, BUSY}, {31'b0, exp_busy});
         if (prev && TX_START) begin
            n_tests++; n_fail++;
            $display("FAIL tx_start_back_to_back: got 1 expected 0 at %0t", $time);
         end
         if (TX_START) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL tx_unexpected: got start data %0h expected none at %0t", TX_DATA, $time);
            end else begin
               e = exp_q.pop_front();
               chk("tx_data", {24'b0, TX_DATA}, {24'b0, e});
            end
            got_q.push_back(TX_DATA);
            held = TX_DATA;
            holding = 1'b1;
         end else if (holding) chk("tx_stable", {24'b0, TX_DATA}, {24'b0, held});
         if (TX_DONE) holding = 1'b0;
         prev = TX_START;
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      RX_DATA = b;
      RX_DONE = 1'b1;
      cyc();
      RX_DONE = 1'b0;
   endtask

   task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                      input int d1, input int d2, input bit inj, input bit sim);
      got_q.delete();
      model_push(a, b, op);
      send(a);
      exp_busy = 1'b1;
      send(b);
      send(op);
      chk("exec_no_start", {31'b0, TX_START}, 32'd0);
      cyc();
      chk("res_latency", {31'b0, TX_START}, 32'd1);
      cyc();
      for (int i = 0; i < d1; i++) begin
         if (inj && i == 1) send(8'h55);
         else cyc();
      end
      TX_DONE = 1'b1;
      cyc();
      TX_DONE = 1'b0;
      chk("stat_latency", {31'b0, TX_START}, 32'd1);
      cyc();
      repeat (d2) cyc();
      TX_DONE = 1'b1;
      if (sim) begin
         RX_DONE = 1'b1;
         RX_DATA = 8'hEE;
      end
      cyc();
      TX_DONE = 1'b0;
      RX_DONE = 1'b0;
      exp_busy = 1'b0;
      chk("datoa", {24'b0, DATOA}, {24'b0, a});
      chk("datob", {24'b0, DATOB}, {24'b0, b});
      chk("opcode", {26'b0, OPCODE}, {26'b0, op[5:0]});
   endtask

   task automatic pin(input string name, input logic [7:0] r, input logic [7:0] s);
      chk({name, "_count"}, got_q.size(), 32'd2);
      chk({name, "_res"}, {24'b0, got_q[0]}, {24'b0, r});
      chk({name, "_stat"}, {24'b0, got_q[1]}, {24'b0, s});
   endtask

   initial begin
      logic [7:0] legal_ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
      logic [7:0] a, b, op;
      int sel;
      #1 RESET_N = 1'b0;
      #1;
      chk("rst_datoa", {24'b0, DATOA}, 32'd0);
      chk("rst_datob", {24'b0, DATOB}, 32'd0);
      chk("rst_opcode", {26'b0, OPCODE}, 32'd0);
      chk("rst_txdata", {24'b0, TX_DATA}, 32'd0);
      chk("rst_txstart", {31'b0, TX_START}, 32'd0);
      chk("rst_busy", {31'b0, BUSY}, 32'd0);
      repeat (2) cyc();
      RESET_N = 1'b1;
      cyc();

      txn(8'hC8, 8'hC8, 8'h20, 3, 2, 1'b0, 1'b0);
      pin("add_carry", 8'h90, 8'h01);
      txn(8'h08, 8'h02, 8'h22, 1, 0, 1'b0, 1'b0);
      pin("sub", 8'h06, 8'h00);
      txn(8'h07, 8'h02, 8'h3F, 2, 1, 1'b0, 1'b0);
      pin("illegal", 8'h00, 8'h02);
      txn(8'h09, 8'h03, 8'h20, 6, 1, 1'b1, 1'b0);
      pin("inject", 8'h0C, 8'h00);
      txn(8'h04, 8'h01, 8'h20, 2, 2, 1'b0, 1'b0);
      pin("after_inject", 8'h05, 8'h00);
      txn(8'hF0, 8'h0F, 8'h26, 100, 3, 1'b0, 1'b1);
      pin("long_wait", 8'hFF, 8'h00);
      txn(8'h04, 8'h01, 8'h20, 1, 1, 1'b0, 1'b0);
      pin("after_simul", 8'h05, 8'h00);

      // Reset in WAIT_STAT must act without a clock edge.
      got_q.delete();
      model_push(8'h33, 8'h11, 8'h20);
      send(8'h33);
      exp_busy = 1'b1;
      send(8'h11);
      send(8'h20);
      repeat (3) cyc();
      TX_DONE = 1'b1;
      cyc();
      TX_DONE = 1'b0;
      repeat (2) cyc();
      #2 RESET_N = 1'b0;
      exp_busy = 1'b0;
      #1;
      chk("async_txstart", {31'b0, TX_START}, 32'd0);
      chk("async_busy", {31'b0, BUSY}, 32'd0);
      chk("async_datoa", {24'b0, DATOA}, 32'd0);
      chk("async_txdata", {24'b0, TX_DATA}, 32'd0);
      cyc();
      RESET_N = 1'b1;
      cyc();
      txn(8'h04, 8'h01, 8'h20, 2, 1, 1'b0, 1'b0);
      pin("after_reset", 8'h05, 8'h00);

      for (int i = 0; i < 30; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         sel = $urandom_range(0, 3);
         op = legal_ops[$urandom_range(0, 7)];
         if (sel == 2) op = {2'($urandom_range(1, 3)), op[5:0]};
         if (sel == 3) op = 8'($urandom);
         txn(a, b, op, $urandom_range(1, 6), $urandom_range(0, 5),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cyc();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
